dcache_controller: RTL
======================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 8 lines x 4 bytes, direct-mapped: tag=ADDRESS[7:5], index=ADDRESS[4:2], offset=ADDRESS[1:0].
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port READ, input, 1 bit: CPU load request.
REQ-005 SHALL have port WRITE, input, 1 bit: CPU store request.
REQ-006 SHALL have port ADDRESS, input, 8 bits: CPU byte address.
REQ-007 SHALL have port WRITEDATA, input, 8 bits: CPU store byte.
REQ-008 SHALL have port READDATA, output, 8 bits: CPU load byte.
REQ-009 SHALL have port BUSYWAIT, output, 1 bit: CPU stall.
REQ-010 SHALL have port MEM_READ, output, 1 bit: memory block-read strobe.
REQ-011 SHALL have port MEM_WRITE, output, 1 bit: memory block-write strobe.
REQ-012 SHALL have port MEM_ADDRESS, output, 6 bits: memory block address {tag,index}.
REQ-013 SHALL have port MEM_WRITEDATA, output, 32 bits: write-back block; byte0 in bits [7:0].
REQ-014 SHALL have port MEM_READDATA, input, 32 bits: fill block, same byte order as MEM_WRITEDATA.
REQ-015 SHALL have port MEM_BUSYWAIT, input, 1 bit: memory busy; an operation completes at the first posedge with MEM_BUSYWAIT=0.

Function
REQ-016 SHALL store per line: valid bit, dirty bit, 3-bit tag, 32-bit data; policy is write-back, write-allocate.
REQ-017 SHALL define hit = valid[index] & (tag[index]==tag).
REQ-018 SHALL implement an FSM with states IDLE, WRITEBACK and FETCH.
REQ-019 SHALL, in IDLE, drive BUSYWAIT = (READ|WRITE) & ~hit, combinationally in the same cycle the request appears.
REQ-020 SHALL, on an IDLE read hit, drive READDATA with the addressed byte combinationally, with 0-cycle latency and no stall.
REQ-021 SHALL, on an IDLE write hit, write WRITEDATA into the addressed byte and set dirty at the next posedge, with no stall.
REQ-022 SHALL drive READDATA=8'h00 whenever there is no read hit in IDLE.
REQ-023 SHALL, on an IDLE miss, transition at the next posedge to WRITEBACK if the victim line is valid and dirty, else to FETCH.
REQ-024 SHALL, in WRITEBACK, assert MEM_WRITE=1 with MEM_ADDRESS={victim tag,index} and MEM_WRITEDATA=victim data, and hold them until the completing posedge, then go to FETCH.
REQ-025 SHALL, in FETCH, assert MEM_READ=1 with MEM_ADDRESS={tag,index}; at the completing posedge it SHALL load MEM_READDATA, set tag, set valid=1, clear dirty, and go to IDLE.
REQ-026 SHALL, after a fill, return to IDLE, where the held request then hits and completes per REQ-020/021; miss penalty is one IDLE cycle plus the memory cycles.
REQ-027 SHALL hold BUSYWAIT=1 throughout WRITEBACK and FETCH.
REQ-028 SHALL drive MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0 and MEM_WRITEDATA=0 in IDLE.
REQ-029 SHALL never assert MEM_READ and MEM_WRITE together.
REQ-030 SHALL, when READ and WRITE are both high, treat the request as a read and leave the line unmodified.
REQ-031 SHALL require the CPU to hold ADDRESS, WRITEDATA, READ and WRITE stable while BUSYWAIT=1; behaviour is unspecified otherwise.
REQ-032 SHALL, if the request drops in IDLE, issue no memory operation.
REQ-033 SHALL, if the request drops mid-WRITEBACK or mid-FETCH, complete the current memory operation before returning to IDLE.

Reset
REQ-034 SHALL, while RESET=1, force the state to IDLE and clear all valid and dirty bits, taking effect immediately and asynchronously, including mid-WRITEBACK or mid-FETCH.
REQ-035 SHALL drive MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0 and BUSYWAIT=0 during reset with no request; tag and data arrays are not reset.

Verification
REQ-036 SHALL cover a cold read miss: after reset, READ at ADDRESS=8'hA5 -> BUSYWAIT=1 the same cycle; FETCH with MEM_ADDRESS=6'h29; memory returns 32'h44332211 after 3 busy cycles -> READDATA=8'h22, BUSYWAIT=0.
REQ-037 SHALL cover a write hit then read hit: WRITE 8'h7E to 8'hA4, then READ 8'hA4 -> no stall on either; READDATA=8'h7E; dirty[1]=1.
REQ-038 SHALL cover a dirty eviction: after REQ-037, READ 8'h24 -> WRITEBACK with MEM_ADDRESS=6'h29 and MEM_WRITEDATA=32'h4433227E, then FETCH with MEM_ADDRESS=6'h09, then a hit.
REQ-039 SHALL cover a clean eviction: READ to a clean conflicting line -> no MEM_WRITE pulse; FETCH only.
REQ-040 SHALL cover reset mid-FETCH: RESET pulsed during FETCH -> MEM_READ=0 immediately; a subsequent READ to the same address misses again.
REQ-041 SHALL cover simultaneous READ and WRITE on a hit line -> READDATA equals the stored byte, the line is unchanged, and dirty is unchanged.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back / write-allocate data cache: 8 lines x 4 bytes.
// Hits complete combinationally in IDLE; misses walk WRITEBACK (dirty victim)
// and FETCH against a block memory, then replay the held request in IDLE.
module dcache_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int unsigned LINES   = 8;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BLOCK_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    state_t               state;
    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_W-1:0]     tags [LINES];
    logic [BLOCK_W-1:0]   data [LINES];

    // Request captured at the miss so the fill does not depend on the CPU holding it
    logic [TAG_W-1:0]     miss_tag;
    logic [IDX_W-1:0]     miss_index;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     index;
    logic [1:0]           offset;
    logic [4:0]           bit_base;
    logic                 hit;
    logic                 read_hit;
    logic                 write_hit;
    logic                 miss;
    logic                 fill_done;

    assign req_tag   = ADDRESS[7:5];
    assign index     = ADDRESS[4:2];
    assign offset    = ADDRESS[1:0];
    assign bit_base  = {offset, 3'b000};
    assign hit       = valid[index] && (tags[index] == req_tag);
    // A simultaneous READ and WRITE is served as a read only
    assign read_hit  = (state == IDLE) && READ && hit;
    assign write_hit = (state == IDLE) && WRITE && !READ && hit;
    assign miss      = (state == IDLE) && (READ || WRITE) && !hit;
    assign fill_done = (state == FETCH) && !MEM_BUSYWAIT;

    // CPU-facing outputs respond in the same cycle as the request
    assign BUSYWAIT = (state == IDLE) ? miss : 1'b1;
    assign READDATA = read_hit ? data[index][bit_base +: BYTE_W] : '0;

    // Controller FSM with registered memory-side strobes and line status bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            miss_tag      <= '0;
            miss_index    <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_hit) begin
                        dirty[index] <= 1'b1;
                    end else if (miss) begin
                        miss_tag   <= req_tag;
                        miss_index <= index;
                        if (valid[index] && dirty[index]) begin
                            state         <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tags[index], index};
                            MEM_WRITEDATA <= data[index];
                        end else begin
                            state       <= FETCH;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {req_tag, index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state         <= FETCH;
                        MEM_WRITE     <= 1'b0;
                        MEM_WRITEDATA <= '0;
                        MEM_READ      <= 1'b1;
                        MEM_ADDRESS   <= {miss_tag, miss_index};
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state             <= IDLE;
                        MEM_READ          <= 1'b0;
                        MEM_ADDRESS       <= '0;
                        valid[miss_index] <= 1'b1;
                        dirty[miss_index] <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage: byte writes on hits, whole-block loads on fills
    always_ff @(posedge CLK) begin
        if (write_hit) begin
            data[index][bit_base +: BYTE_W] <= WRITEDATA;
        end
        if (fill_done) begin
            data[miss_index] <= MEM_READDATA;
            tags[miss_index] <= miss_tag;
        end
    end

endmodule
